// File: rtl/intmul_pkg.sv
// Shared definitions for the multiplier arbiter and its response FIFO.
//   WIDTH          operand width of the shared multiplier
//   PWIDTH         product width (exact, 2*WIDTH)
//   MUL_LAT        multiplier latency, cycles from A/B sampled to D valid
//   NREQ_DEF       default number of requesters
//   NREQ_MAX       largest supported number of requesters
//   FIFO_DEPTH_DEF default result FIFO depth
//   id_width()     width of a client index for n clients
//   rsp_entry_t    one queued response: issuing client id and product
package intmul_pkg;

    localparam int WIDTH          = 255;
    localparam int PWIDTH         = 2 * WIDTH;
    localparam int MUL_LAT        = 2;
    localparam int NREQ_DEF       = 4;
    localparam int NREQ_MAX       = 8;
    localparam int FIFO_DEPTH_DEF = 8;

    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Sized for the largest client count so any legal NREQ fits in the entry.
    localparam int ID_W = id_width(NREQ_MAX);

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [PWIDTH-1:0] d;
    } rsp_entry_t;

endpackage

// File: rtl/intmul.sv
// Pipelined unsigned integer multiplier, d = a * b after LAT cycles.
// Operands are registered on the first edge, the product on the next,
// with any further latency as plain product delay stages. No reset: the
// caller tracks which outputs are meaningful.
//   clk  in   clock
//   a    in   WIDTH   operand A
//   b    in   WIDTH   operand B
//   d    out  PWIDTH  product of the a/b presented LAT cycles earlier
module intmul
    import intmul_pkg::*;
#(
    parameter int LAT = MUL_LAT
) (
    input  logic              clk,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    output logic [PWIDTH-1:0] d
);

    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic [PWIDTH-1:0] prod_q [LAT-1];

    // NOTE: pure datapath flops carry no reset; validity travels separately.
    always_ff @(posedge clk) begin
        a_q       <= a;
        b_q       <= b;
        prod_q[0] <= PWIDTH'(a_q) * PWIDTH'(b_q);
        for (int i = 1; i < LAT - 1; i++) begin
            prod_q[i] <= prod_q[i-1];
        end
    end

    assign d = prod_q[LAT-2];

endmodule

// File: rtl/intmul_rsp_fifo.sv
// Synchronous result FIFO with a registered head entry.
// The head register always holds the entry at the read pointer, so the
// consumer sees data in the same cycle the FIFO becomes non-empty and the
// outputs stay stable while nothing is popped.
//   clk      in   clock
//   rst      in   asynchronous active-high reset, empties the FIFO
//   push     in   write wr_data
//   wr_data  in   entry to append
//   pop      in   drop the head entry (ignored when empty)
//   head     out  oldest entry (registered)
//   full     out  DEPTH entries held
//   empty    out  no entries held
//   count    out  occupancy
module intmul_rsp_fifo
    import intmul_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  rsp_entry_t             wr_data,
    input  logic                   pop,
    output rsp_entry_t             head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    rsp_entry_t  mem [DEPTH];
    rsp_entry_t  head_q;
    rsp_entry_t  head_nxt;
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [AW:0] rd_ptr_nxt;
    logic        do_push;
    logic        do_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count   = wr_ptr - rd_ptr;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign rd_ptr_nxt = rd_ptr + (AW+1)'(do_pop);

    // Next head: the incoming entry when it lands in an otherwise empty
    // FIFO, else whatever sits at the next read slot; hold when empty.
    always_comb begin
        head_nxt = head_q;
        if (wr_ptr == rd_ptr_nxt) begin
            if (do_push) begin
                head_nxt = wr_data;
            end
        end else begin
            head_nxt = mem[rd_ptr_nxt[AW-1:0]];
        end
    end

    // NOTE: storage array is not reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            head_q <= '0;
        end else begin
            wr_ptr <= wr_ptr + (AW+1)'(do_push);
            rd_ptr <= rd_ptr_nxt;
            head_q <= head_nxt;
        end
    end

    assign head = head_q;

    a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && full && !pop));

endmodule

// File: rtl/intmul_arbiter.sv
// Shares one pipelined multiplier among NREQ clients.
// Round-robin grant over valid/ready request ports, an issue register in
// front of the multiplier, an id/valid pipe alongside it, and a response
// FIFO guarded by a credit counter so it can never overflow. Responses
// leave in issue order on a single backpressured port.
//   clk        in   clock
//   rst        in   asynchronous active-high reset
//   req_valid  in   NREQ          per-client request valid
//   req_ready  out  NREQ          per-client accept, one-hot or zero
//   req_a      in   NREQ*WIDTH    client i operand A at [i*WIDTH +: WIDTH]
//   req_b      in   NREQ*WIDTH    client i operand B, same packing
//   rsp_valid  out  response available
//   rsp_ready  in   consumer accepts response
//   rsp_id     out  client index that issued the product
//   rsp_d      out  2*WIDTH       exact product A*B
module intmul_arbiter
    import intmul_pkg::*;
#(
    parameter int NREQ       = NREQ_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*WIDTH-1:0]   req_a,
    input  logic [NREQ*WIDTH-1:0]   req_b,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [$clog2(NREQ)-1:0] rsp_id,
    output logic [2*WIDTH-1:0]      rsp_d
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [IW-1:0]               rr_q;
    logic [IW-1:0]               scan_idx;
    logic [IW-1:0]               grant_idx;
    logic                        grant_any;
    logic                        credit_ok;
    logic                        handshake;
    logic [CW-1:0]               cnt_q;

    logic                        issue_vld_q;
    logic [IW-1:0]               issue_id_q;
    logic [WIDTH-1:0]            op_a_q;
    logic [WIDTH-1:0]            op_b_q;
    logic [MUL_LAT-1:0]          vld_pipe;
    logic [MUL_LAT-1:0][IW-1:0]  id_pipe;
    logic [PWIDTH-1:0]           mul_d;

    logic                        push;
    logic                        pop;
    rsp_entry_t                  push_entry;
    rsp_entry_t                  head;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic [CW-1:0]               fifo_count;

    // Round-robin scan: first valid client at or after the rr pointer.
    // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        scan_idx  = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan_idx = IW'((int'(rr_q) + k) % NREQ);
            if (!grant_any && req_valid[scan_idx]) begin
                grant_any = 1'b1;
                grant_idx = scan_idx;
            end
        end
    end

    // Credits cover in-flight ops plus queued results, so every accepted op
    // is guaranteed a FIFO slot when it reaches the multiplier output.
    assign credit_ok = (cnt_q < CW'(FIFO_DEPTH));

    always_comb begin
        req_ready = '0;
        if (!rst && grant_any && credit_ok) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    assign handshake = |req_ready;
    assign pop       = rsp_valid && rsp_ready;

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_q        <= '0;
            cnt_q       <= '0;
            issue_vld_q <= 1'b0;
            issue_id_q  <= '0;
            vld_pipe    <= '0;
            id_pipe     <= '0;
        end else begin
            if (handshake) begin
                rr_q       <= (grant_idx == IW'(NREQ - 1)) ? '0 : grant_idx + IW'(1);
                issue_id_q <= grant_idx;
            end
            cnt_q       <= cnt_q + CW'(handshake) - CW'(pop);
            issue_vld_q <= handshake;
            vld_pipe    <= {vld_pipe[MUL_LAT-2:0], issue_vld_q};
            id_pipe     <= {id_pipe[MUL_LAT-2:0], issue_id_q};
        end
    end

    // Operands hold their last value when idle to avoid toggling the multiplier.
    always_ff @(posedge clk) begin
        if (handshake) begin
            op_a_q <= req_a[grant_idx*WIDTH +: WIDTH];
            op_b_q <= req_b[grant_idx*WIDTH +: WIDTH];
        end
    end

    intmul #(
        .LAT (MUL_LAT)
    ) u_intmul (
        .clk (clk),
        .a   (op_a_q),
        .b   (op_b_q),
        .d   (mul_d)
    );

    assign push          = vld_pipe[MUL_LAT-1];
    assign push_entry.id = ID_W'(id_pipe[MUL_LAT-1]);
    assign push_entry.d  = mul_d;

    intmul_rsp_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_rsp_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .wr_data (push_entry),
        .pop     (pop),
        .head    (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign rsp_valid = !fifo_empty;
    assign rsp_id    = IW'(head.id);
    assign rsp_d     = head.d;

    a_credit_covers_fifo: assert property (@(posedge clk) disable iff (rst) cnt_q >= fifo_count);
    a_full_blocks_accept: assert property (@(posedge clk) disable iff (rst) !(fifo_full && credit_ok));

endmodule

// File: tb/tb_intmul_arbiter.sv
module tb_intmul_arbiter;
    import intmul_pkg::*;

    localparam int N     = 4;
    localparam int DEPTH = 8;
    localparam int IW    = 2;
    localparam int W     = WIDTH;
    localparam int PW    = PWIDTH;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [IW-1:0]  rsp_id;
    logic [PW-1:0]  rsp_d;

    intmul_arbiter #(
        .NREQ       (N),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_d     (rsp_d)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int id; logic [PW-1:0] d; } exp_t;
    typedef struct { int cyc; int id; } pop_t;

    exp_t sb[$];
    pop_t pop_log[$];

    int n_cmp = 0;
    int n_fail = 0;
    int n_acc = 0;     // accepts since the last reset (credit model)
    int n_pop = 0;     // responses consumed
    int n_grant = 0;   // accepts over the whole run
    int dut_acc = 0;   // handshakes seen on the DUT ports
    int rr_m = 0;

    logic          pend_v   [N];
    logic [W-1:0]  pend_a   [N];
    logic [W-1:0]  pend_b   [N];
    logic [PW-1:0] pend_exp [N];

    task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [W-1:0] rand_op();
        logic [255:0] t;
        int m;
        m = $urandom_range(0, 9);
        for (int i = 0; i < 8; i++) t[i*32 +: 32] = $urandom();
        if (m == 0) t = '1;
        else if (m == 1) t = '0;
        else if (m == 2) t = 256'($urandom_range(0, 15));
        return t[W-1:0];
    endfunction

    task automatic new_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        pend_v[i]   = 1'b1;
        pend_a[i]   = a;
        pend_b[i]   = b;
        pend_exp[i] = PW'(a) * PW'(b);
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_valid[i]      = pend_v[i];
            req_a[i*W +: W]   = pend_a[i];
            req_b[i*W +: W]   = pend_b[i];
        end
    endtask

    // Reference: grant the first pending client from the rr pointer while
    // outstanding (accepted but not yet consumed) work is below the depth.
    task automatic model();
        logic [N-1:0] exp_rdy;
        int w;
        exp_rdy = '0;
        w = -1;
        if (!rst && (n_acc - n_pop) < DEPTH) begin
            for (int k = 0; k < N; k++) begin
                if (w < 0 && pend_v[(rr_m + k) % N]) w = (rr_m + k) % N;
            end
        end
        if (w >= 0) exp_rdy[w] = 1'b1;
        check("req_ready", PW'(req_ready), PW'(exp_rdy));
        if ((req_ready & req_valid) != '0) dut_acc++;
        if (w >= 0) begin
            sb.push_back('{w, pend_exp[w]});
            n_acc++;
            n_grant++;
            rr_m = (w + 1) % N;
            pend_v[w] = 1'b0;
        end
    endtask

    task automatic step();
        drive();
        @(negedge clk);
        model();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        for (int i = 0; i < N; i++) pend_v[i] = 1'b0;
        req_valid = '1;
        rst = 1'b1;
        sb.delete();
        n_acc = n_pop;
        rr_m = 0;
        @(negedge clk);
        check("rst_req_ready", PW'(req_ready), '0);
        check("rst_rsp_valid", PW'(rsp_valid), '0);
        check("rst_rsp_id", PW'(rsp_id), '0);
        check("rst_rsp_d", rsp_d, '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive();
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        rsp_ready = 1'b1;
        while ((sb.size() != 0 || pend_v[0] || pend_v[1] || pend_v[2] || pend_v[3]) && guard < 300) begin
            step();
            guard++;
        end
        check("drain_empty", PW'(sb.size()), '0);
    endtask

    // Monitor: consumes responses and compares them with the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (!rst && rsp_valid) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL rsp_unexpected @cyc %0d: got id %0d d %0h expected no response", cyc, rsp_id, rsp_d);
                end else if (rsp_ready) begin
                    e = sb.pop_front();
                    check("rsp_id", PW'(rsp_id), PW'(e.id));
                    check("rsp_d", rsp_d, e.d);
                    pop_log.push_back('{cyc, int'(rsp_id)});
                    n_pop++;
                end
            end
        end
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c0;
        int start;
        int guard;
        logic [PW:0] one;
        logic [PW:0] big;

        rst = 1'b1;
        rsp_ready = 1'b0;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        for (int i = 0; i < N; i++) begin
            pend_v[i] = 1'b0;
            pend_a[i] = '0;
            pend_b[i] = '0;
            pend_exp[i] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // 1: single op, client 2, 3*5, response exactly 4 cycles later
        rsp_ready = 1'b1;
        pop_log.delete();
        new_op(2, W'(3), W'(5));
        c0 = cyc;
        step();
        repeat (8) step();
        check("t1_count", PW'(pop_log.size()), PW'(1));
        check("t1_latency", PW'(pop_log.size() > 0 ? pop_log[0].cyc - c0 : -1), PW'(4));
        check("t1_id", PW'(pop_log.size() > 0 ? pop_log[0].id : -1), PW'(2));

        // 2: max operands, expected 2^510 - 2^256 + 1 in closed form
        new_op(1, '1, '1);
        one = 1;
        big = (one << 510) - (one << 256) + one;
        pend_exp[1] = big[PW-1:0];
        step();
        repeat (8) step();

        // 3: contention from rr=0, grants 0..3 back to back, responses in cycles 4..7
        do_reset();
        pop_log.delete();
        for (int i = 0; i < N; i++) new_op(i, rand_op(), rand_op());
        c0 = cyc;
        repeat (12) step();
        check("t3_count", PW'(pop_log.size()), PW'(4));
        for (int i = 0; i < 4; i++) begin
            check("t3_cycle", PW'(pop_log.size() > i ? pop_log[i].cyc - c0 : -1), PW'(4 + i));
            check("t3_id", PW'(pop_log.size() > i ? pop_log[i].id : -1), PW'(i));
        end

        // 4: backpressure, client 0 streams against a stalled consumer
        rsp_ready = 1'b0;
        start = dut_acc;
        repeat (16) begin
            if (!pend_v[0]) new_op(0, rand_op(), rand_op());
            step();
        end
        check("t4_accepts", PW'(dut_acc - start), PW'(DEPTH));
        rsp_ready = 1'b1;
        repeat (24) begin
            if (!pend_v[0]) new_op(0, rand_op(), rand_op());
            step();
        end
        drain();

        // 5: reset with three ops in flight, nothing stale afterwards
        new_op(0, rand_op(), rand_op());
        new_op(1, rand_op(), rand_op());
        new_op(3, rand_op(), rand_op());
        repeat (3) step();
        do_reset();
        repeat (10) begin
            step();
            check("t5_no_stale", PW'(rsp_valid), '0);
        end

        // 6: random traffic and random consumer stalls
        start = n_grant;
        guard = 0;
        while ((n_grant - start) < 10000 && guard < 60000) begin
            if (((guard / 500) % 2) == 0) rsp_ready = 1'b1;
            else rsp_ready = ($urandom_range(0, 9) < 7);
            for (int i = 0; i < N; i++) begin
                if (!pend_v[i] && $urandom_range(0, 3) != 0) new_op(i, rand_op(), rand_op());
            end
            step();
            guard++;
        end
        check("t6_ops_done", PW'((n_grant - start) >= 10000), PW'(1));
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
